// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch controller bus: run control, imem port, decode handshake, redirect
interface fetch_controller_if;
  logic        Run;
  logic [31:0] IMem_Addr;
  logic [31:0] IMem_Data;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Fault;

  modport master (
    input  Run, IMem_Data, Instr_Ready, Redirect, Redirect_PC,
    output IMem_Addr, Instr, Instr_PC, Instr_Valid, Fault
  );

  modport slave (
    output Run, IMem_Data, Instr_Ready, Redirect, Redirect_PC,
    input  IMem_Addr, Instr, Instr_PC, Instr_Valid, Fault
  );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC sequencer with prefetch queue; FETCH_BOUND_CHECK_EN enables the imem range fault
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          QDEPTH     = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  fetch_controller_if.master  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || IMEM_WORDS < 1) begin : g_bad_cfg
    $error("fetch_controller: QDEPTH must be a power of 2 >= 2 and IMEM_WORDS >= 1");
  end

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [29:0] IMEM_WORDS_C = 30'(IMEM_WORDS);
`endif

  logic [1:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   q_pc_q [QDEPTH];
  logic [31:0]   q_pc_d [QDEPTH];
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_instr_d [QDEPTH];
  logic          fault_q, fault_d;

  logic not_empty, pop, push, fetch_en, out_of_range;

  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty && bus.Instr_Ready;
    // Run high in IDLE fetches in the same cycle so the first word is valid one cycle later.
    fetch_en  = bus.Run && (state_q != FAULT);
`ifdef FETCH_BOUND_CHECK_EN
    out_of_range = (fpc_q[31:2] >= IMEM_WORDS_C);
`else
    out_of_range = 1'b0;
`endif
    push = fetch_en && !bus.Redirect && !out_of_range && ((count_q != FULL) || pop);
  end

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;
    fault_d   = fault_q;

    if (bus.Redirect) begin
      // A pop in this cycle is absorbed by the flush.
      fpc_d   = bus.Redirect_PC & 32'hFFFF_FFFC;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      fault_d = 1'b0;
      state_d = bus.Run ? FETCH : IDLE;
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push) begin
        q_pc_d[tail_q]    = fpc_q;
        q_instr_d[tail_q] = bus.IMem_Data;
        tail_d            = tail_q + 1'b1;
        fpc_d             = fpc_q + 32'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      case (state_q)
        IDLE:    if (bus.Run) state_d = out_of_range ? FAULT : FETCH;
        FETCH:   if (!bus.Run) state_d = IDLE;
                 else if (out_of_range) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase

`ifdef FETCH_BOUND_CHECK_EN
      if (fetch_en && out_of_range) fault_d = 1'b1;
`else
      fault_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fault_q   <= fault_d;
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
    end
  end

  assign bus.IMem_Addr   = {2'b00, fpc_q[31:2]};
  assign bus.Instr_Valid = not_empty;
  assign bus.Instr       = not_empty ? q_instr_q[head_q] : 32'h0;
  assign bus.Instr_PC    = not_empty ? q_pc_q[head_q] : 32'h0;
  assign bus.Fault       = fault_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed and random checks of fetch_controller against a queue-based reference model
module tb_fetch_controller;
  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 Clk = ~Clk;

  fetch_controller_if bus();

  fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(64),
    .QDEPTH    (2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  function automatic logic [31:0] memf(input logic [31:0] widx);
    return (widx < 32'd64) ? (32'h1000_0000 + widx) : (32'hEEEE_0000 ^ widx);
  endfunction

  assign bus.IMem_Data = memf(bus.IMem_Addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mfpc  = 32'h0;
  bit          mfault = 1'b0;

  task automatic model_step(input bit rst, run, ready, redir, input logic [31:0] rpc);
    bit pop, oor, room;
    ent_t e;
    if (rst) begin
      mq.delete(); mfpc = 32'h0; mfault = 1'b0;
    end else if (redir) begin
      mq.delete(); mfpc = rpc & ~32'h3; mfault = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && ready;
      oor  = BC && ((mfpc >> 2) >= 32'd64);
      room = (mq.size() < 2) || pop;
      if (pop) mq.delete(0);
      if (run && !mfault) begin
        if (oor) mfault = 1'b1;
        else if (room) begin
          e.pc = mfpc; e.instr = memf(mfpc >> 2);
          mq.push_back(e);
          mfpc = mfpc + 32'd4;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("instr_valid", 32'(bus.Instr_Valid), 32'(mq.size() != 0));
    chk("instr",       bus.Instr,    (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk("instr_pc",    bus.Instr_PC, (mq.size() != 0) ? mq[0].pc    : 32'h0);
    chk("imem_addr",   bus.IMem_Addr, mfpc >> 2);
    chk("fault",       32'(bus.Fault), 32'(mfault));
  endtask

  task automatic step(input bit rst, run, ready, redir, input logic [31:0] rpc);
    Rst             = rst;
    bus.Run         = run;
    bus.Instr_Ready = ready;
    bus.Redirect    = redir;
    bus.Redirect_PC = rpc;
    model_step(rst, run, ready, redir, rpc);
    @(posedge Clk);
    @(negedge Clk);
    check_all();
  endtask

  initial begin
    bit          r_rst, r_run, r_rdy, r_red;
    logic [31:0] r_pc;

    Rst = 1'b1; bus.Run = 1'b0; bus.Instr_Ready = 1'b0;
    bus.Redirect = 1'b0; bus.Redirect_PC = 32'h0;

    // Reset values.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_valid", 32'(bus.Instr_Valid), 32'h0);
    chk("reset_addr",  bus.IMem_Addr, 32'h0);

    // Back-to-back stream from cycle 1.
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 1, 0, 0);
      chk("stream_pc",    bus.Instr_PC, 32'(4 * (k - 1)));
      chk("stream_instr", bus.Instr,    32'h1000_0000 + 32'(k - 1));
    end

    // Backpressure: queue fills to 2, IMem_Addr frozen at word 2.
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0, 0, 0);
      if (k >= 2) chk("stall_addr", bus.IMem_Addr, 32'd2);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 0, 0);
      chk("resume_pc", bus.Instr_PC, 32'(4 * i));
    end

    // Redirect while full; low address bits ignored.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0043);
    chk("redir_valid", 32'(bus.Instr_Valid), 32'h0);
    step(0, 1, 0, 0, 0);
    chk("redir_pc",    bus.Instr_PC, 32'h40);
    chk("redir_instr", bus.Instr,    32'h1000_0010);

    // Run dropped with two queued: both drain, then idle with stable address.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("drain_pc", bus.Instr_PC, 32'h44);
    step(0, 0, 1, 0, 0);
    chk("drain_empty", 32'(bus.Instr_Valid), 32'h0);
    step(0, 0, 1, 0, 0);
    chk("drain_addr", bus.IMem_Addr, 32'd18);

    // Reset overrides a simultaneous redirect.
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 32'h80);
    chk("rst_redir_valid", 32'(bus.Instr_Valid), 32'h0);
    chk("rst_redir_addr",  bus.IMem_Addr, 32'h0);
    chk("rst_redir_instr", bus.Instr, 32'h0);

`ifdef FETCH_BOUND_CHECK_EN
    step(0, 1, 1, 1, 32'hFC);
    step(0, 1, 1, 0, 0);
    chk("bound_pc",    bus.Instr_PC, 32'hFC);
    chk("bound_instr", bus.Instr,    32'h1000_003F);
    step(0, 1, 1, 0, 0);
    chk("bound_fault", 32'(bus.Fault), 32'h1);
    step(0, 1, 1, 0, 0);
    chk("bound_nopush", 32'(bus.Instr_Valid), 32'h0);
    step(0, 1, 1, 1, 32'h0);
    chk("bound_clear", 32'(bus.Fault), 32'h0);
    step(0, 1, 1, 0, 0);
    chk("bound_resume", bus.Instr, 32'h1000_0000);
`endif

    // Randomized traffic against the model, including redirects near the PC wrap.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_run = ($urandom_range(0, 9) < 8);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_red = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else r_pc = 32'($urandom_range(0, 'h11F));
      step(r_rst, r_run, r_rdy, r_red, r_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer for the single-issue MIPS core. It owns the fetch program counter and drives the word-indexed, combinational-read instruction memory. It buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake. Decode or execute redirects it on branches and jumps by flushing the queue and reloading the PC.

## Interface
- RESET_PC, 32'h0000_0000, byte address of first fetch after reset
- IMEM_WORDS, 64, instruction memory depth in 32-bit words
- QDEPTH, 2, prefetch queue entries (power of 2, ≥2)

- Clk  in  1  single clock, all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Run  in  1  fetch enable; low stops new fetches, queue still drains
- IMem_Addr  out  32  word index into instruction memory = {2'b00, FPC[31:2]}
- IMem_Data  in  32  instruction word, valid combinationally in same cycle as IMem_Addr
- Instr  out  32  queue-head instruction; 0 when queue empty
- Instr_PC  out  32  byte PC of Instr; 0 when queue empty
- Instr_Valid  out  1  queue non-empty
- Instr_Ready  in  1  decode accepts head this cycle
- Redirect  in  1  flush and reload PC (branch/jump taken)
- Redirect_PC  in  32  new byte PC; bits [1:0] ignored, forced to 00
- Fault  out  1  fetch address out of range (sticky; see Configuration)

## Operation
- State: FPC (32b), queue of {PC, instr} entries, occupancy count (clog2(QDEPTH)+1 bits), FSM.
- FSM states: IDLE, FETCH, FAULT.
  - IDLE -> FETCH when Run=1.
  - FETCH -> IDLE when Run=0.
  - FETCH -> FAULT on out-of-range FPC (macro only).
  - FAULT -> FETCH on Redirect with in-range target and Run=1; FAULT -> IDLE on Redirect with Run=0.
  - Any state: Redirect reloads FPC.
- Push: in FETCH, Redirect=0, and (count<QDEPTH or pop this cycle) -> enqueue {FPC, IMem_Data}, FPC <= FPC+4.
  - FPC wraps modulo 2^32.
- Pop: Instr_Valid && Instr_Ready -> dequeue head.
  - Simultaneous push+pop is legal at any occupancy, including full; count unchanged.
- Redirect has absolute priority:
  - queue emptied and count <= 0;
  - FPC <= {Redirect_PC[31:2], 2'b00};
  - no push; any pop that cycle is discarded (head counted as consumed);
  - Fault cleared.
- Queue pointers wrap modulo QDEPTH. Instr/Instr_PC are read from head, muxed to 0 when empty.

## Timing
- Reset values:
  - FPC=RESET_PC, IMem_Addr=RESET_PC>>2, count=0, FSM=IDLE
  - Instr=0, Instr_PC=0, Instr_Valid=0, Fault=0
- Rst mid-operation overrides Redirect and Run; queue contents discarded.
- Fetch latency: Run sampled high in cycle N -> push at end of N -> Instr_Valid=1 in cycle N+1.
  - IMem_Addr changes in the cycle after each push.
- Throughput: one instruction/cycle with Instr_Ready held high.
- Instr_Ready low: queue fills to QDEPTH, then FPC holds and IMem_Addr is stable.
- Redirect in cycle N: Instr_Valid=0 in N+1. First redirected instruction valid in N+2 if Run=1.
- Instr_Valid never depends combinationally on Instr_Ready. Instr_Ready may depend on Instr_Valid.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - In FETCH, when FPC[31:2] ≥ IMEM_WORDS: no push, FSM -> FAULT, Fault=1 next cycle (sticky).
  - Entries already queued still drain.
  - Redirect to an in-range target clears the fault.
- Not defined:
  - No range check; Fault tied 0; FAULT state unreachable.
  - IMem_Addr carries FPC[31:2] unchanged; out-of-range behaviour belongs to the memory.

## Test plan
- Reset, Run=1, Ready=1, memory word k = 0x1000_0000+k -> Instr_PC 0,4,8,… and Instr 0x1000_0000,0x1000_0001,… back-to-back from cycle 1; no gaps.
- Ready=0 for 5 cycles, then 1 -> count saturates at QDEPTH=2, IMem_Addr frozen at 2, no word lost or duplicated on resume.
- Redirect=1, Redirect_PC=0x0000_0043 while queue full -> next cycle Instr_Valid=0. Following cycle Instr_PC=0x40, Instr=word 16.
- Run dropped mid-stream with 2 queued, Ready=1 -> both entries delivered, then Instr_Valid=0, IMem_Addr stable.
- Macro on, Redirect_PC=0xFC (word 63), Run=1 -> word 63 delivered, then Fault=1, no further push. Redirect to 0x0 -> Fault=0, fetch resumes at word 0.
- Rst asserted same cycle as Redirect with a non-empty queue -> next cycle all outputs at reset values, FPC=RESET_PC.
